sync_gray_pointer: RTL and testbench
====================================

# sync_gray_pointer

Parametrised read-domain synchroniser for gray-coded FIFO pointers; successor to the fixed two-flop pointer sync. Takes an asynchronous gray pointer from the foreign domain through a configurable-depth flop chain, and presents both the synchronised gray value and a registered binary decode. It also emits a per-update change strobe, a post-reset valid flag, and a sticky error flag when the sampled value breaks the one-bit-per-step gray rule. It sits in the FIFO between the write-pointer crossing and the empty/level logic.

## Interface
- ADDR_SIZE, 8, pointer is ADDR_SIZE+1 bits (address plus wrap bit); legal ≥1
- STAGES, 2, synchroniser flop depth; legal ≥2, elaboration error otherwise
- r_clk_i  input  1  destination-domain clock; all state on rising edge
- r_rst_i  input  1  reset, asynchronous assert, active-low
- gray_ptr_i  input  ADDR_SIZE+1  gray pointer from foreign domain, asynchronous to r_clk_i
- err_clr_i  input  1  synchronous clear of gray_err_o
- gray_ptr_o  output  ADDR_SIZE+1  synchronised gray pointer, last chain stage
- bin_ptr_o  output  ADDR_SIZE+1  registered binary decode of gray_ptr_o
- ptr_chg_o  output  1  one-cycle pulse: bin_ptr_o just took a new value
- valid_o  output  1  chain has flushed since reset; outputs trustworthy
- gray_err_o  output  1  sticky: consecutive synchronised samples differed in >1 bit

## Operation
- Chain: stage[0] <= gray_ptr_i; stage[k] <= stage[k-1]; gray_ptr_o = stage[STAGES-1]. No logic between stages.
- Decode register: gray_q <= gray_ptr_o; bin_ptr_o <= g2b(gray_ptr_o), with b[MSB]=g[MSB] and b[i]=b[i+1]^g[i].
- diff = gray_ptr_o ^ gray_q.
- Change: ptr_chg_o <= valid_o && (diff != 0).
- Warm-up counter: width clog2(STAGES+2). Counts edges after reset release and saturates at STAGES+1. valid_o is a register set when the count reaches STAGES+1, and it stays high until the next reset.
- Error: gray_err_o is set when valid_o && popcount(diff) > 1. It is cleared by err_clr_i. If set and clear occur in the same cycle, set wins.
- Wrap: pointer roll-over (e.g. gray 100…0 -> 000…0) is a single-bit change. It must not flag an error, and it must pulse ptr_chg_o.
- Reset (any time, including mid-stream): all chain stages, gray_q, bin_ptr_o, the counter, and every output go to 0 asynchronously. After release, the warm-up restarts from zero.

## Timing
- gray_ptr_i captured at edge n -> gray_ptr_o valid after edge n+STAGES-1 (STAGES flops including capture).
- bin_ptr_o and ptr_chg_o: one edge after gray_ptr_o, so STAGES+1 flop latency.
- valid_o: high from edge STAGES+1 after reset release. Before that, ptr_chg_o and error setting are masked.
- gray_err_o: asserts one edge after the offending sample appears on gray_ptr_o. err_clr_i takes effect at the next edge.
- Steady input: ptr_chg_o stays low. Input changing every cycle: ptr_chg_o pulses every cycle.

## Structure
- Shared FIFO package holds:
  - the g2b function (parametrised width)
  - a multi_bit_change function (popcount > 1 on a vector)
  - a MIN_SYNC_STAGES = 2 constant
- Sub-module sync_stage_chain (WIDTH, STAGES) contains the bare flop chain with async active-low reset and no other logic. Mark it for CDC tools and synthesis as a synchroniser (no retiming or merging).
- Top-level sync_gray_pointer instantiates sync_stage_chain and adds the decode register, warm-up counter, change and error logic.

## Test plan
- Reset release, STAGES=3, ADDR_SIZE=3, gray_ptr_i=0:
  - valid_o rises at edge 4
  - all other outputs stay 0
  - no ptr_chg_o pulse
- After valid, gray_ptr_i steps through gray sequence 0..15 one per cycle:
  - bin_ptr_o = 0..15 lagging 4 edges
  - ptr_chg_o high 16 consecutive cycles
  - gray_err_o stays 0
- Wrap (ADDR_SIZE=3): gray 1000 -> 0000:
  - bin_ptr_o 15 -> 0
  - ptr_chg_o pulses once
  - gray_err_o stays 0
- Inject 0000 -> 0011 after valid:
  - gray_err_o=1 STAGES+1 edges later, and it holds
- Clear behaviour:
  - err_clr_i for one cycle clears the flag
  - err_clr_i asserted in the same cycle as a new violation leaves gray_err_o=1
- Reset mid-stream with gray_ptr_i=0101:
  - all outputs 0 immediately on r_rst_i low
  - after release, valid_o is low for STAGES edges
  - no spurious error or change pulse when the chain refills with 0101

Source files
------------

// File: rtl/sync_gray_pointer_pkg.sv
// Shared FIFO pointer helpers: gray-to-binary decode, multi-bit change detect,
// and the minimum synchroniser depth.
package sync_gray_pointer_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 2;

  // Helpers operate on a wide vector; callers zero-extend and truncate with casts.
  localparam int unsigned MAX_PTR_W = 64;

  // Leading zero bits leave the prefix-XOR unchanged, so any narrower width decodes correctly.
  function automatic logic [MAX_PTR_W-1:0] g2b(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic multi_bit_change(input logic [MAX_PTR_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_PTR_W; i++) begin
      n += 32'(v[i]);
    end
    return (n > 1);
  endfunction

endpackage

// File: rtl/sync_stage_chain.sv
// Bare multi-flop synchroniser: no logic between stages, async active-low reset.
module sync_stage_chain #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Keep these flops together and un-retimed so metastability settles inside the chain.
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int unsigned k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/sync_gray_pointer.sv
// Read-domain synchroniser for a gray-coded FIFO pointer with registered binary
// decode, change strobe, post-reset valid and sticky gray-rule error flag.
module sync_gray_pointer
  import sync_gray_pointer_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned STAGES    = 2
) (
  input  logic               r_clk_i,
  input  logic               r_rst_i,
  input  logic [ADDR_SIZE:0] gray_ptr_i,
  input  logic               err_clr_i,
  output logic [ADDR_SIZE:0] gray_ptr_o,
  output logic [ADDR_SIZE:0] bin_ptr_o,
  output logic               ptr_chg_o,
  output logic               valid_o,
  output logic               gray_err_o
);

  localparam int unsigned PTR_W = ADDR_SIZE + 1;
  localparam int unsigned CNT_W = $clog2(STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_VALID = CNT_W'(STAGES);

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("sync_gray_pointer: STAGES must be at least %0d", MIN_SYNC_STAGES);
  end
  if (ADDR_SIZE < 1 || PTR_W > MAX_PTR_W) begin : g_bad_addr
    $error("sync_gray_pointer: ADDR_SIZE out of range");
  end

  logic [PTR_W-1:0] gray_sync;
  logic [PTR_W-1:0] gray_q;
  logic [PTR_W-1:0] bin_q;
  logic [PTR_W-1:0] bin_d;
  logic [PTR_W-1:0] diff;
  logic             multi_bit;
  logic             chg_q;
  logic             valid_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  sync_stage_chain #(
    .WIDTH  (PTR_W),
    .STAGES (STAGES)
  ) u_chain (
    .clk   (r_clk_i),
    .rst_n (r_rst_i),
    .d     (gray_ptr_i),
    .q     (gray_sync)
  );

  always_comb begin
    diff      = gray_sync ^ gray_q;
    bin_d     = PTR_W'(g2b(MAX_PTR_W'(gray_sync)));
    multi_bit = multi_bit_change(MAX_PTR_W'(diff));
  end

  // valid is set on the edge the counter reaches STAGES+1, one edge after the
  // chain's last reset-zero has been overwritten and compared in gray_q.
  always_ff @(posedge r_clk_i or negedge r_rst_i) begin
    if (!r_rst_i) begin
      gray_q  <= '0;
      bin_q   <= '0;
      chg_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      gray_q <= gray_sync;
      bin_q  <= bin_d;
      chg_q  <= valid_q && (diff != '0);
      if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (cnt_q == CNT_VALID) begin
        valid_q <= 1'b1;
      end
      // A new violation outranks a simultaneous clear.
      err_q <= (valid_q && multi_bit) || (err_q && !err_clr_i);
    end
  end

  assign gray_ptr_o = gray_sync;
  assign bin_ptr_o  = bin_q;
  assign ptr_chg_o  = chg_q;
  assign valid_o    = valid_q;
  assign gray_err_o = err_q;

endmodule

// File: tb/tb_sync_gray_pointer.sv
// Directed bench for sync_gray_pointer with ADDR_SIZE=3, STAGES=3.
module tb_sync_gray_pointer;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       err_clr;
  logic [3:0] gray_out;
  logic [3:0] bin_out;
  logic       chg;
  logic       valid;
  logic       err;

  int vectors;
  int miscompares;

  logic [3:0] gray_tab [16];

  sync_gray_pointer #(
    .ADDR_SIZE (3),
    .STAGES    (3)
  ) dut (
    .r_clk_i    (clk),
    .r_rst_i    (rst_n),
    .gray_ptr_i (gray_in),
    .err_clr_i  (err_clr),
    .gray_ptr_o (gray_out),
    .bin_ptr_o  (bin_out),
    .ptr_chg_o  (chg),
    .valid_o    (valid),
    .gray_err_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] b,
                           input logic c, input logic v, input logic e);
    check({tag, ".gray"}, 8'(gray_out), 8'(g));
    check({tag, ".bin"}, 8'(bin_out), 8'(b));
    check({tag, ".chg"}, 8'(chg), 8'(c));
    check({tag, ".valid"}, 8'(valid), 8'(v));
    check({tag, ".err"}, 8'(err), 8'(e));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    rst_n   = 1'b0;
    gray_in = 4'h0;
    err_clr = 1'b0;
    repeat (2) tick();
    check_all("in_reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Release away from the edge; valid must rise on edge 4.
    rst_n = 1'b1;
    for (int m = 1; m <= 5; m++) begin
      tick();
      check_all($sformatf("warmup%0d", m), 4'h0, 4'h0, 1'b0, (m >= 4), 1'b0);
    end

    // Gray count 1..15 then wrap 1000 -> 0000: one change per cycle.
    for (int m = 1; m <= 21; m++) begin
      if (m <= 16) gray_in = gray_tab[m & 15];
      tick();
      check($sformatf("seq%0d.bin", m), 8'(bin_out),
            (m >= 4 && m <= 19) ? 8'((m - 3) & 15) : 8'h0);
      check($sformatf("seq%0d.chg", m), 8'(chg), 8'(m >= 4 && m <= 19));
      check($sformatf("seq%0d.err", m), 8'(err), 8'h0);
    end

    // Two-bit jump 0000 -> 0011 sets the sticky error.
    gray_in = 4'h3;
    repeat (3) tick();
    check("jump.err_before", 8'(err), 8'h0);
    tick();
    check_all("jump", 4'h3, 4'h2, 1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    check_all("jump_hold", 4'h3, 4'h2, 1'b0, 1'b1, 1'b1);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clear.err", 8'(err), 8'h0);
    tick();
    check("clear_stays.err", 8'(err), 8'h0);

    // Clear held across a fresh violation: the set must win.
    gray_in = 4'hC;
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    check("set_vs_clr.err", 8'(err), 8'h1);
    check("set_vs_clr.bin", 8'(bin_out), 8'h8);
    tick();
    err_clr = 1'b0;
    check("clr_after.err", 8'(err), 8'h0);

    // Mid-stream reset while the chain is filling with 0101.
    gray_in = 4'h5;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    check_all("rst_hold", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      tick();
      check($sformatf("refill%0d.valid", m), 8'(valid), 8'h0);
      check($sformatf("refill%0d.chg", m), 8'(chg), 8'h0);
      check($sformatf("refill%0d.err", m), 8'(err), 8'h0);
    end
    tick();
    check_all("refill4", 4'h5, 4'h6, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    check_all("refill6", 4'h5, 4'h6, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
